// File: rtl/motor_pwm_slave.sv
// motor_pwm_slave: Avalon-MM slave driving NUM_MOTORS brushed-motor H-bridges.
// Shared PWM timebase, per-channel slew-limited duty, reversal through zero
// duty, and a bus watchdog that shuts every channel down when writes stop.
module motor_pwm_slave #(
  parameter int NUM_MOTORS = 6,
  parameter int DUTY_WIDTH = 8,
  parameter int PRESCALE   = 4,
  parameter int RAMP_STEP  = 4,
  parameter int WDT_CYCLES = 50000000,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    write,
  input  logic                    read,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [2*NUM_MOTORS-1:0] motor_out,
  output logic                    wdt_tripped
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]         PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [DUTY_WIDTH-1:0] STEP       = DUTY_WIDTH'(RAMP_STEP);
  localparam logic [31:0]           STEP32     = 32'(RAMP_STEP);
  localparam logic [31:0]           WDT_LOAD   = 32'(WDT_CYCLES);

  logic [NUM_MOTORS-1:0]                 enable_q, dir_q, applied_dir, dir_nxt, ramping;
  logic [NUM_MOTORS-1:0][DUTY_WIDTH-1:0] duty_q, applied, app_nxt, target, up, dn;
  logic [PW-1:0]         presc;
  logic [DUTY_WIDTH-1:0] tick;
  logic [31:0]           wdt_cnt, addr32, rd_mux;
  logic                  boundary, expire, wr_status;

  assign addr32    = 32'(address);
  assign boundary  = (presc == PRESC_LAST) && (tick == '1);
  assign wr_status = write && (addr32 == 32'd2);
  // A write in the expiry cycle reloads the counter instead of tripping.
  assign expire    = (WDT_CYCLES != 0) && (wdt_cnt == '0) && !write;

  // Shared PWM timebase: prescaler feeding a free-running tick counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      tick  <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      tick  <= tick + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Software-visible control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q <= '0;
      dir_q    <= '0;
      duty_q   <= '0;
    end else if (write) begin
      if (addr32 == 32'd0) enable_q <= writedata[NUM_MOTORS-1:0];
      if (addr32 == 32'd1) dir_q    <= writedata[NUM_MOTORS-1:0];
      for (int i = 0; i < NUM_MOTORS; i++)
        if (addr32 == 32'(4 + i)) duty_q[i] <= writedata[DUTY_WIDTH-1:0];
    end
  end

  // Watchdog: any write reloads; trip latches until W1C on STATUS[0].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdt_cnt     <= WDT_LOAD;
      wdt_tripped <= 1'b0;
    end else begin
      if (write)              wdt_cnt <= WDT_LOAD;
      else if (wdt_cnt != '0) wdt_cnt <= wdt_cnt - 1'b1;
      if (wr_status && writedata[0]) wdt_tripped <= 1'b0;
      else if (expire)               wdt_tripped <= 1'b1;
    end
  end

  // Per-channel effective target, slew-limited ramp and reversal-at-zero.
  always_comb begin
    target  = '0;
    ramping = '0;
    up      = '0;
    dn      = '0;
    app_nxt = applied;
    dir_nxt = applied_dir;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      if (enable_q[i] && !wdt_tripped && (dir_q[i] == applied_dir[i]))
        target[i] = duty_q[i];
      ramping[i] = (applied[i] != target[i]);
      up[i] = target[i] - applied[i];
      dn[i] = applied[i] - target[i];
      if (wdt_tripped) begin
        app_nxt[i] = '0;
      end else if (boundary) begin
        if (applied[i] < target[i])
          app_nxt[i] = (32'(up[i]) > STEP32) ? applied[i] + STEP : target[i];
        else if (applied[i] > target[i])
          app_nxt[i] = (32'(dn[i]) > STEP32) ? applied[i] - STEP : target[i];
      end
      if (boundary && (applied[i] == '0) && (dir_q[i] != applied_dir[i]))
        dir_nxt[i] = dir_q[i];
    end
  end

  // Applied state register and registered H-bridge outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      applied     <= '0;
      applied_dir <= '0;
      motor_out   <= '0;
    end else begin
      applied     <= app_nxt;
      applied_dir <= dir_nxt;
      for (int i = 0; i < NUM_MOTORS; i++) begin
        motor_out[2*i]   <= (tick < applied[i]) && !applied_dir[i];
        motor_out[2*i+1] <= (tick < applied[i]) &&  applied_dir[i];
      end
    end
  end

  // Read mux; unmapped addresses and unused bits read as zero.
  always_comb begin
    rd_mux = '0;
    case (addr32)
      32'd0: rd_mux[NUM_MOTORS-1:0] = enable_q;
      32'd1: rd_mux[NUM_MOTORS-1:0] = dir_q;
      32'd2: begin
        rd_mux[0] = wdt_tripped;
        for (int i = 0; i < NUM_MOTORS; i++) begin
          rd_mux[8+i] = ramping[i];
          if (20 + i < 32) rd_mux[20+i] = applied_dir[i];
        end
      end
      default: begin
        for (int i = 0; i < NUM_MOTORS; i++)
          if (addr32 == 32'(4 + i)) rd_mux[DUTY_WIDTH-1:0] = duty_q[i];
      end
    endcase
  end

  // Registered read data, zero when no read was issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else       readdata <= read ? rd_mux : '0;
  end
endmodule

// File: tb/tb_motor_pwm_slave.sv
// tb_motor_pwm_slave: directed stimulus, cycle-level reference model and
// hand-computed expectations for motor_pwm_slave.
module tb_motor_pwm_slave;
  localparam int NM = 6, DW = 8, PS = 4, RS = 4, WDT = 1000, AW = 4;
  localparam int PERIOD = (1 << DW) * PS;

  logic          clk = 1'b0, reset = 1'b1, write = 1'b0, read = 1'b0;
  logic [AW-1:0] address = '0;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [2*NM-1:0] motor_out;
  logic          wdt_tripped;

  int checks = 0, errors = 0;
  int hi0[64], hi1[64];
  int overlap = 0;

  motor_pwm_slave #(.NUM_MOTORS(NM), .DUTY_WIDTH(DW), .PRESCALE(PS),
                    .RAMP_STEP(RS), .WDT_CYCLES(WDT), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .address(address), .write(write), .read(read),
    .writedata(writedata), .readdata(readdata), .motor_out(motor_out),
    .wdt_tripped(wdt_tripped));

  initial forever #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [NM-1:0] m_en = '0, m_dir = '0, m_adir = '0;
  int m_duty[NM], m_app[NM];
  int m_edges = 0, m_quiet = 0;
  bit m_trip = 1'b0;
  logic [31:0] m_rd = '0;
  logic [2*NM-1:0] m_mo = '0;

  function automatic int eff_target(input int c);
    return (m_en[c] && !m_trip && (m_dir[c] == m_adir[c])) ? m_duty[c] : 0;
  endfunction

  function automatic logic [31:0] reg_read(input int a);
    logic [31:0] v;
    v = '0;
    if (a == 0) v = 32'(m_en);
    else if (a == 1) v = 32'(m_dir);
    else if (a == 2) begin
      v[0] = m_trip;
      for (int c = 0; c < NM; c++) begin
        v[8+c]  = (m_app[c] != eff_target(c));
        v[20+c] = m_adir[c];
      end
    end else if (a >= 4 && a < 4 + NM) v = 32'(m_duty[a-4]);
    return v;
  endfunction

  task automatic model_reset();
    m_en = '0; m_dir = '0; m_adir = '0; m_trip = 1'b0;
    m_edges = 0; m_quiet = 0; m_rd = '0; m_mo = '0;
    for (int c = 0; c < NM; c++) begin m_duty[c] = 0; m_app[c] = 0; end
  endtask

  task automatic model_step();
    int tk, a, lim;
    bit bnd;
    int tgt[NM], nxt[NM];
    logic [NM-1:0] nadir;
    tk  = (m_edges / PS) % (1 << DW);
    bnd = (m_edges % PERIOD) == PERIOD - 1;
    a   = int'(address);
    for (int c = 0; c < NM; c++) begin
      m_mo[2*c]   = (tk < m_app[c]) && !m_adir[c];
      m_mo[2*c+1] = (tk < m_app[c]) &&  m_adir[c];
      tgt[c] = eff_target(c);
    end
    m_rd = read ? reg_read(a) : '0;
    for (int c = 0; c < NM; c++) begin
      nxt[c] = m_app[c];
      lim = (tgt[c] > m_app[c]) ? tgt[c] - m_app[c] : m_app[c] - tgt[c];
      if (lim > RS) lim = RS;
      if (m_trip) nxt[c] = 0;
      else if (bnd) nxt[c] = (tgt[c] > m_app[c]) ? m_app[c] + lim : m_app[c] - lim;
      nadir[c] = (bnd && m_app[c] == 0 && m_dir[c] != m_adir[c]) ? m_dir[c] : m_adir[c];
    end
    if (write) m_quiet = 0; else m_quiet++;
    if (write && a == 2 && writedata[0]) m_trip = 1'b0;
    else if (!write && m_quiet > WDT) m_trip = 1'b1;
    if (write) begin
      if (a == 0) m_en = writedata[NM-1:0];
      else if (a == 1) m_dir = writedata[NM-1:0];
      else if (a >= 4 && a < 4 + NM) m_duty[a-4] = int'(writedata[DW-1:0]);
    end
    for (int c = 0; c < NM; c++) m_app[c] = nxt[c];
    m_adir = nadir;
    m_edges++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset(); else model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every cycle: DUT outputs against the model, plus per-period high counts.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("cyc readdata", readdata, m_rd);
      chk("cyc motor_out", 32'(motor_out), 32'(m_mo));
      chk("cyc wdt_tripped", 32'(wdt_tripped), 32'(m_trip));
      if (m_edges > 0 && (m_edges - 1) / PERIOD < 64) begin
        hi0[(m_edges-1)/PERIOD] += motor_out[0] ? 1 : 0;
        hi1[(m_edges-1)/PERIOD] += motor_out[1] ? 1 : 0;
      end
      for (int c = 0; c < NM; c++)
        if (motor_out[2*c] && motor_out[2*c+1]) overlap++;
    end
  end

  // ---------------- driver ----------------
  task automatic bus(input logic w, input logic r, input int a, input logic [31:0] d);
    @(negedge clk);
    write = w; read = r; address = AW'(a); writedata = d;
  endtask

  task automatic idle(input int n, input bit kick);
    for (int i = 0; i < n; i++)
      if (kick && m_quiet >= 500) bus(1'b1, 1'b0, 3, 0);
      else bus(1'b0, 1'b0, 0, 0);
  endtask

  task automatic rd(input int a, input logic [31:0] exp, input string name);
    bus(1'b0, 1'b1, a, 0);
    bus(1'b0, 1'b0, 0, 0);
    chk(name, readdata, exp);
  endtask

  task automatic wait_edges(input int t);
    while (m_edges < t) idle(1, 1'b1);
  endtask

  initial begin
    int n, pc;
    for (int p = 0; p < 64; p++) begin hi0[p] = 0; hi1[p] = 0; end
    repeat (3) @(negedge clk);
    chk("reset readdata", readdata, 0);
    chk("reset motor_out", 32'(motor_out), 0);
    chk("reset wdt", 32'(wdt_tripped), 0);
    reset = 1'b0;

    // Register access, truncation, unmapped, write+read same cycle.
    bus(1'b1, 1'b0, 9, 32'h1FF);
    rd(9, 32'h0000_00FF, "duty5 trunc");
    rd(15, 0, "unmapped 15");
    bus(1'b1, 1'b1, 9, 32'h12);
    bus(1'b0, 1'b0, 0, 0);
    chk("rw same cycle old", readdata, 32'h0000_00FF);
    rd(9, 32'h12, "duty5 new");

    // Ramp 0 -> 10 on channel 0.
    bus(1'b1, 1'b0, 0, 32'h01);
    bus(1'b1, 1'b0, 4, 10);
    wait_edges(1500);
    rd(2, 32'h0000_0100, "status ramping");
    wait_edges(3500);
    rd(2, 0, "status settled");
    chk("hi0 p0", hi0[0], 0);
    chk("hi0 p1 duty4", hi0[1], 16);
    chk("hi0 p2 duty8", hi0[2], 32);

    // Lower duty mid-period, then reverse through zero.
    bus(1'b1, 1'b0, 4, 8);
    wait_edges(4500);
    bus(1'b1, 1'b0, 1, 32'h01);
    wait_edges(9300);
    chk("hi0 p3 duty10", hi0[3], 40);
    chk("hi0 p4 duty8", hi0[4], 32);
    chk("hi0 p5 duty4", hi0[5], 16);
    chk("hi0 p6 zero", hi0[6], 0);
    chk("hi1 p6 zero", hi1[6], 0);
    chk("hi1 p7 zero", hi1[7], 0);
    chk("hi1 p8 rev4", hi1[8], 16);
    chk("hi0 p8 off", hi0[8], 0);
    rd(2, 32'h0010_0000, "status reversed");

    // Watchdog trip timed early in a period while reverse is high.
    do idle(1, 1'b1); while (m_edges % PERIOD != 27);
    write = 1'b1; read = 1'b0; address = AW'(3);
    chk("hi1 p9 rev8", hi1[9], 32);
    n = 0;
    do begin idle(1, 1'b0); n++; end while (!wdt_tripped && n < 1100);
    chk("wdt trip latency", n, 1002);
    chk("trip mo t0", 32'(motor_out[1]), 1);
    idle(1, 1'b0);
    chk("trip mo t1", 32'(motor_out[1]), 1);
    idle(1, 1'b0);
    chk("trip mo t2", 32'(motor_out), 0);
    rd(2, 32'h0010_0001, "status tripped");
    rd(4, 8, "duty0 retained");
    rd(0, 1, "enable retained");
    bus(1'b1, 1'b0, 2, 1);
    bus(1'b0, 1'b0, 0, 0);
    pc = m_edges / PERIOD + 1;
    chk("w1c clears", 32'(wdt_tripped), 0);
    rd(2, 32'h0010_0100, "status after w1c");
    wait_edges((pc + 2) * PERIOD + 2);
    chk("rearm ramp 4", hi1[pc], 16);
    chk("rearm ramp 8", hi1[pc+1], 32);

    // Periodic kicks, then writes landing exactly on the expiry cycle.
    for (int k = 0; k < 11; k++) begin bus(1'b1, 1'b0, 3, 0); idle(899, 1'b0); end
    chk("kick 900 no trip", 32'(wdt_tripped), 0);
    bus(1'b1, 1'b0, 3, 0);
    idle(1000, 1'b0);
    chk("counter at zero no trip", 32'(wdt_tripped), 0);
    bus(1'b1, 1'b0, 3, 0);
    idle(1000, 1'b0);
    bus(1'b1, 1'b0, 2, 1);
    idle(5, 1'b1);
    chk("w1c at expiry", 32'(wdt_tripped), 0);
    chk("no fwd/rev overlap", overlap, 0);

    // Asynchronous reset while channel 2 is driving.
    bus(1'b1, 1'b0, 1, 0);
    bus(1'b1, 1'b0, 6, 200);
    bus(1'b1, 1'b0, 0, 32'h04);
    idle(3 * PERIOD, 1'b1);
    n = 0;
    while (!motor_out[4] && n < 2 * PERIOD) begin idle(1, 1'b1); n++; end
    chk("ch2 running", 32'(motor_out[4]), 1);
    #2 reset = 1'b1;
    #1;
    chk("async reset motor_out", 32'(motor_out), 0);
    chk("async reset readdata", readdata, 0);
    chk("async reset wdt", 32'(wdt_tripped), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 16; a++) rd(a, 0, $sformatf("post-reset reg %0d", a));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
endmodule

// File: doc/motor_pwm_slave.md
Name: motor_pwm_slave

Overview:
Parametrised Avalon-MM slave for NUM_MOTORS brushed motors. It generates the PWM internally; no separate per-motor controller module is instantiated. Each channel has its own duty register, slew-limited ramping and safe direction reversal through zero duty. A bus watchdog shuts all motors down if software stops writing. Outputs drive H-bridge inputs on GPIO pins through the SOPC configuration.

Parameters:
NUM_MOTORS, 6, number of motor channels (1..12)
DUTY_WIDTH, 8, duty/PWM counter width; PWM period = 2^DUTY_WIDTH * PRESCALE clocks
PRESCALE, 4, clocks per PWM counter tick (>=1)
RAMP_STEP, 4, maximum change of applied duty per PWM period
WDT_CYCLES, 50000000, clocks without a bus write before trip; 0 disables watchdog
ADDR_WIDTH, 4, word address width; must satisfy 2^ADDR_WIDTH >= 4+NUM_MOTORS

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
address  in  ADDR_WIDTH  word address
write  in  1  write strobe, one transfer per cycle
read  in  1  read strobe
writedata  in  32  write data
readdata  out  32  read data, valid the cycle after read
motor_out  out  2*NUM_MOTORS  per motor i: bit 2i = forward PWM, bit 2i+1 = reverse PWM
wdt_tripped  out  1  watchdog trip flag (mirrors STATUS[0])

Behaviour:
- Register map (word address):
  - 0 ENABLE: [NUM_MOTORS-1:0] per-motor enable, RW.
  - 1 DIR: [NUM_MOTORS-1:0] requested direction, 1 = reverse, RW.
  - 2 STATUS:
    - [0] wdt_tripped, W1C.
    - [8+:NUM_MOTORS] ramping (applied duty != effective target), RO.
    - [20+:NUM_MOTORS] applied direction, RO; only bits below 32 exist, upper channels readable via DIR only.
  - 3 KICK: write any value; no state besides the watchdog reload.
  - 4+i DUTY[i]: [DUTY_WIDTH-1:0] target duty, RW.
  - Unmapped: writes ignored, reads return 0.
- Reads: readdata registered; data for address sampled with read appears next cycle. Unused bits are 0. readdata = 0 in cycles without a preceding read.
- Reset: all registers, applied duty, applied direction, counters and wdt_tripped = 0. readdata = 0 and motor_out = 0 immediately, independent of clk.
- PWM:
  - Shared prescaler counts 0..PRESCALE-1.
  - Shared DUTY_WIDTH-bit tick counter increments on prescaler wrap and wraps naturally.
  - Period boundary = cycle where prescaler and tick counter both wrap to 0.
  - Channel i drives active = (tick < applied_duty[i]), registered one cycle.
  - Duty 0 gives constant low; full-scale 2^DUTY_WIDTH-1 gives high for all but one tick.
  - The active signal goes to bit 2i when applied_dir=0, bit 2i+1 when 1. The other bit is 0. Both bits are never 1 simultaneously.
- Effective target per channel:
  - 0 if ENABLE[i]=0, or wdt_tripped, or DIR[i] != applied_dir[i].
  - Otherwise DUTY[i].
- Ramp, evaluated only at period boundary:
  - If applied < target: applied += min(RAMP_STEP, target-applied).
  - If applied > target: applied -= min(RAMP_STEP, applied-target).
  - No overflow or underflow past target.
- Direction reversal: at a period boundary where applied_duty[i]==0 and DIR[i] != applied_dir[i], applied_dir[i] <= DIR[i]. Ramp-up starts at the next boundary.
- Watchdog:
  - Down-counter reloads to WDT_CYCLES on reset and on any write to any address.
  - At 0 (and WDT_CYCLES != 0), wdt_tripped <= 1.
  - Trip forces applied_duty of all channels to 0 on the next clock, bypassing the ramp, and motor_out to 0 the cycle after.
  - ENABLE/DUTY/DIR registers are retained.
  - Trip cleared only by writing 1 to STATUS[0]. That write also reloads the counter. Ramp restarts from 0.
- Simultaneous events:
  - Write and watchdog expiry in the same cycle: the write wins, no trip.
  - W1C and expiry in the same cycle: flag stays clear.
  - Write and read in the same cycle to the same address: readdata returns the old value.
- Mid-operation target change: takes effect at the next boundary via the ramp; no glitch within a period.

Test Plan:
- Reset asserted mid-PWM with duty 200 running -> motor_out=0 in the same cycle, all registers read 0 after release.
- NUM_MOTORS=6, PRESCALE=4, RAMP_STEP=4: ENABLE=0x01, DUTY[0]=10 -> applied duty 4, 8, 10 over three periods of 1024 clocks; forward high exactly 40 clocks per period in the third period; STATUS[8] clears after reaching 10.
- Channel 0 at duty 8 forward, write DIR=0x01 -> ramps 4, 0; bit 1 then rises only after the period with duty 0; bit 0 and bit 1 never high together.
- WDT_CYCLES=1000, no writes for 1000 clocks -> wdt_tripped=1, motor_out=0 two cycles later; write STATUS=1 -> flag clears, channel ramps from 0 back to DUTY.
- Write KICK every 900 clocks for 10000 clocks -> no trip; write on exact expiry cycle -> no trip.
- Read DUTY[5] after writing 0x1FF with DUTY_WIDTH=8 -> readdata=0x000000FF one cycle after read; read address 15 -> 0.
